lift_call_queue: RTL
====================

LIFT_CALL_QUEUE -- requirements
Module: lift_call_queue

Interface
REQ-001 The block SHALL have parameter FLOORS, default 8, meaning number of served floors.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning call FIFO entries (power of two, 2..8).
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive high samples needed to accept a press (used only under LIFT_CALL_DEBOUNCE_EN).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn  input  FLOORS  raw floor call buttons, level, one bit per floor.
REQ-007 emergency_stop  input  1  level; flushes and blocks all calls while high.
REQ-008 req_ready  input  1  downstream lift controller accepts req_floor this cycle.
REQ-009 req_floor  output  3  floor number at FIFO head.
REQ-010 req_valid  output  1  req_floor is valid.
REQ-011 pending  output  FLOORS  bitmap of floors currently held in the FIFO.
REQ-012 queue_count  output  4  number of FIFO entries, 0..DEPTH.
REQ-013 full  output  1  queue_count == DEPTH.

Function
REQ-014 Press detection SHALL register btn into btn_prev each cycle; a press on floor f is btn[f] & ~btn_prev[f].
REQ-015 A detected press SHALL set captured[f]; captured[f] SHALL clear when floor f is pushed.
REQ-016 Each cycle at most one push SHALL occur: the lowest-index f with captured[f]=1 and pending[f]=0, provided the FIFO is not full or a pop occurs in the same cycle.
REQ-017 A captured floor already pending SHALL remain captured, not dropped, and SHALL be re-evaluated every cycle.
REQ-018 Push SHALL write f at the tail, set pending[f], and increment queue_count.
REQ-019 Pop SHALL occur when req_valid & req_ready, SHALL clear pending[req_floor], advance the head, and decrement queue_count.
REQ-020 Same-cycle push and pop SHALL leave queue_count unchanged; the pending check uses the pre-pop value, so pushing the floor being popped is deferred one cycle.
REQ-021 req_valid SHALL equal (queue_count != 0); req_floor SHALL be the head entry, and 0 when empty.
REQ-022 Latency: a press sampled at edge k SHALL be captured at edge k, pushed at edge k+1, and req_valid high after edge k+1 when the FIFO was empty.
REQ-023 Ordering SHALL be strict FIFO; when the FIFO is full, captured calls wait without loss.
REQ-024 While emergency_stop=1: FIFO empties, pending and captured clear, no press is captured, req_valid=0 after the next edge.
REQ-025 btn_prev SHALL keep updating during emergency_stop, so a button held through its release creates no press.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-027 On reset at an edge, req_floor, req_valid, pending, queue_count, full, captured, btn_prev, pointers and debounce counters SHALL be 0.
REQ-028 reset SHALL take priority over emergency_stop and all push/pop activity.

Configuration
REQ-029 Macro LIFT_CALL_DEBOUNCE_EN defined: a per-floor counter counts consecutive high samples of btn[f], saturating at DEBOUNCE_CYCLES; a press is detected when the count reaches DEBOUNCE_CYCLES; a low sample zeroes the count.
REQ-030 With LIFT_CALL_DEBOUNCE_EN, press latency SHALL grow by DEBOUNCE_CYCLES-1 cycles.
REQ-031 Macro undefined: detection is the plain edge of REQ-014, and no counters exist.

Structure
REQ-032 Package lift_pkg SHALL hold FLOORS, FLOOR_W=3 and typedef floor_t (FLOOR_W bits).
REQ-033 The FIFO SHALL be sub-module lift_call_fifo (synchronous, parameter DEPTH, push/pop/count/full); priority select and capture logic stay in the top.

Verification
REQ-034 btn[1] pulse 1 cycle after reset, req_ready=0 -> after 2 edges: req_valid=1, req_floor=1, pending=8'h02, queue_count=1.
REQ-035 btn[6] and btn[2] rise in the same cycle -> FIFO order 2 then 6, pushed on consecutive edges.
REQ-036 Press 4 twice while 4 pending, then pop -> only one entry while pending; the second press is pushed the cycle after the pop.
REQ-037 Five distinct presses, DEPTH=4, req_ready=0 -> full=1, queue_count=4, fifth call held; one pop -> fifth pushed next edge, full stays 1.
REQ-038 Queue holding 3 entries, emergency_stop=1 one cycle -> queue_count=0, pending=0, req_valid=0; a button held through stop produces no call.
REQ-039 With LIFT_CALL_DEBOUNCE_EN and a 3-cycle btn[5] pulse -> no call; a 4-cycle pulse -> one call, floor 5.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared floor constants and types for the lift call queue.
package lift_pkg;

  localparam int FLOORS  = 8;
  localparam int FLOOR_W = 3;

  typedef logic [FLOOR_W-1:0] floor_t;

endpackage

// File: rtl/lift_call_fifo.sv
// Synchronous call FIFO of floor numbers with flush, occupancy count and full flag.
module lift_call_fifo
  import lift_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  floor_t     push_floor,
  input  logic       pop,
  output floor_t     head,
  output logic [3:0] count,
  output logic       full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  floor_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [3:0]       count_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop & (count != 4'd0);
  assign do_push = push & (~full | do_pop);
  assign head    = (count != 4'd0) ? mem[rd_ptr] : '0;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 4'd1;
      2'b01:   count_next = count - 4'd1;
      default: count_next = count;
    endcase
  end

  // Pointer, count and full-flag state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 4'd0;
      full   <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 4'd0;
      full   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count_next;
      full  <= (count_next == 4'(DEPTH));
    end
  end

  // Storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) begin
      mem[wr_ptr] <= push_floor;
    end
  end

endmodule

// File: rtl/lift_call_queue.sv
// Lift floor-call queue: press capture, lowest-floor push selection and FIFO hand-off.
// Optional build macro LIFT_CALL_DEBOUNCE_EN replaces edge detection with a per-floor debouncer.
module lift_call_queue
  import lift_pkg::floor_t;
#(
  parameter int FLOORS          = lift_pkg::FLOORS,
  parameter int DEPTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] btn,
  input  logic              emergency_stop,
  input  logic              req_ready,
  output floor_t            req_floor,
  output logic              req_valid,
  output logic [FLOORS-1:0] pending,
  output logic [3:0]        queue_count,
  output logic              full
);

  if (FLOORS < 1 || FLOORS > 8) begin : g_bad_floors
    $error("lift_call_queue: FLOORS must be 1..8");
  end
  if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("lift_call_queue: DEPTH must be a power of two in 2..8");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("lift_call_queue: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [FLOORS-1:0] captured;
  logic [FLOORS-1:0] press;
  logic [FLOORS-1:0] candidate;
  logic [FLOORS-1:0] push_mask;
  logic [FLOORS-1:0] pop_mask;
  logic              sel_found;
  floor_t            sel_floor;
  logic              push;
  logic              pop;
  floor_t            head;
  logic [3:0]        count;
  logic              fifo_full;

`ifdef LIFT_CALL_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] db_cnt [FLOORS];

  // A press fires on the sample that brings the run of highs up to DEBOUNCE_CYCLES.
  always_comb begin
    press = '0;
    for (int i = 0; i < FLOORS; i++) begin
      press[i] = btn[i] && (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
    end
  end

  // Saturating run-length counters; keep counting during emergency stop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FLOORS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FLOORS; i++) begin
        if (!btn[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] != CNT_W'(DEBOUNCE_CYCLES)) begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  logic [FLOORS-1:0] btn_prev;

  assign press = btn & ~btn_prev;

  // Previous button sample; keeps tracking through emergency stop.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_prev <= '0;
    end else begin
      btn_prev <= btn;
    end
  end
`endif

  assign req_valid   = (count != 4'd0);
  assign req_floor   = head;
  assign queue_count = count;
  assign full        = fifo_full;
  assign pop         = req_valid & req_ready & ~emergency_stop;
  // Pre-pop pending: a floor leaving the head this cycle re-enters one cycle later.
  assign candidate   = captured & ~pending;
  assign push        = sel_found & ~emergency_stop & (~fifo_full | pop);

  // Lowest-index candidate wins; scan downward so the last hit is the lowest.
  always_comb begin
    sel_found = 1'b0;
    sel_floor = '0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      sel_floor = candidate[i] ? floor_t'(i) : sel_floor;
      sel_found = sel_found | candidate[i];
    end
  end

  // One-hot views of the pushed and popped floors.
  always_comb begin
    push_mask = '0;
    pop_mask  = '0;
    for (int i = 0; i < FLOORS; i++) begin
      push_mask[i] = push && (sel_floor == floor_t'(i));
      pop_mask[i]  = pop && (head == floor_t'(i));
    end
  end

  // Captured calls persist until pushed; pending mirrors FIFO contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      captured <= '0;
      pending  <= '0;
    end else if (emergency_stop) begin
      captured <= '0;
      pending  <= '0;
    end else begin
      captured <= (captured & ~push_mask) | press;
      pending  <= (pending & ~pop_mask) | push_mask;
    end
  end

  lift_call_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (emergency_stop),
    .push      (push),
    .push_floor(sel_floor),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (fifo_full)
  );

endmodule
